pipe_front_regs: RTL and testbench

- Front-end pipeline state for the 5-stage MIPS PCPU: PC register, IF/ID register and ID/EX register.
- Acts as the consumer/responder of the hazard unit's control outputs (PCWrite, IF_ID_Write, clean, Flush).
- Applies stalls, bubbles and wrong-path flushes cycle-exactly.
- Keeps saturating stall/flush event counters for debug and performance readout.

---
 rtl/pipe_front_regs.sv | 95 +++++++++
 tb/tb_pipe_front_regs.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_front_regs.sv
// Front-end pipeline registers for the 5-stage PCPU: PC, IF/ID and ID/EX.
// Responds to the hazard unit's PCWrite / IF_ID_Write / clean / Flush and
// keeps saturating stall and flush event counters for debug readout.
module pipe_front_regs #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CTRL_W   = 16,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PCWrite,
  input  logic              IF_ID_Write,
  input  logic              clean,
  input  logic              Flush,
  input  logic [31:0]       next_pc,
  input  logic [31:0]       imem_inst,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [31:0]       id_rs_data,
  input  logic [31:0]       id_rt_data,
  output logic [31:0]       pc,
  output logic [31:0]       IF_ID_inst,
  output logic [31:0]       IF_ID_pc4,
  output logic              IF_ID_valid,
  output logic [31:0]       ID_EX_inst,
  output logic [31:0]       ID_EX_pc4,
  output logic [CTRL_W-1:0] ID_EX_ctrl,
  output logic [31:0]       ID_EX_a,
  output logic [31:0]       ID_EX_b,
  output logic              ID_EX_valid,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic id_ex_bubble;
  assign id_ex_bubble = Flush | clean;

  // PC register: loads the selected next PC unless the hazard unit freezes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (PCWrite) begin
      pc <= next_pc;
    end
  end

  // IF/ID: flush squashes, otherwise capture or hold the fetched instruction.
  always_ff @(posedge clk) begin
    if (rst || Flush) begin
      IF_ID_inst  <= 32'h0;
      IF_ID_pc4   <= 32'h0;
      IF_ID_valid <= 1'b0;
    end else if (IF_ID_Write) begin
      IF_ID_inst  <= imem_inst;
      IF_ID_pc4   <= pc + 32'd4;
      IF_ID_valid <= 1'b1;
    end
  end

  // ID/EX: no hold mode; either a bubble or the decoded IF/ID contents.
  always_ff @(posedge clk) begin
    if (rst || id_ex_bubble) begin
      ID_EX_inst  <= 32'h0;
      ID_EX_pc4   <= 32'h0;
      ID_EX_ctrl  <= '0;
      ID_EX_a     <= 32'h0;
      ID_EX_b     <= 32'h0;
      ID_EX_valid <= 1'b0;
    end else begin
      ID_EX_inst  <= IF_ID_inst;
      ID_EX_pc4   <= IF_ID_pc4;
      ID_EX_ctrl  <= id_ctrl;
      ID_EX_a     <= id_rs_data;
      ID_EX_b     <= id_rt_data;
      ID_EX_valid <= IF_ID_valid;
    end
  end

  // Saturating event counters; a flush with clean counts only as a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (clean && !Flush && stall_cnt != CNT_MAX) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (Flush && flush_cnt != CNT_MAX) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_front_regs.sv
// Directed bench for pipe_front_regs: a vector table walks reset, straight-line
// flow, load-use, flush, simultaneous hazards and PC wrap; short hand-written
// sequences cover counter saturation and reset during an active flush.
module tb_pipe_front_regs;

  localparam int CTRL_W = 16;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              PCWrite;
  logic              IF_ID_Write;
  logic              clean;
  logic              Flush;
  logic [31:0]       next_pc;
  logic [31:0]       imem_inst;
  logic [CTRL_W-1:0] id_ctrl;
  logic [31:0]       id_rs_data;
  logic [31:0]       id_rt_data;
  logic [31:0]       pc;
  logic [31:0]       IF_ID_inst;
  logic [31:0]       IF_ID_pc4;
  logic              IF_ID_valid;
  logic [31:0]       ID_EX_inst;
  logic [31:0]       ID_EX_pc4;
  logic [CTRL_W-1:0] ID_EX_ctrl;
  logic [31:0]       ID_EX_a;
  logic [31:0]       ID_EX_b;
  logic              ID_EX_valid;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  int n_cmp;
  int n_bad;

  pipe_front_regs #(
    .RESET_PC (32'h0000_0000),
    .CTRL_W   (CTRL_W),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .PCWrite     (PCWrite),
    .IF_ID_Write (IF_ID_Write),
    .clean       (clean),
    .Flush       (Flush),
    .next_pc     (next_pc),
    .imem_inst   (imem_inst),
    .id_ctrl     (id_ctrl),
    .id_rs_data  (id_rs_data),
    .id_rt_data  (id_rt_data),
    .pc          (pc),
    .IF_ID_inst  (IF_ID_inst),
    .IF_ID_pc4   (IF_ID_pc4),
    .IF_ID_valid (IF_ID_valid),
    .ID_EX_inst  (ID_EX_inst),
    .ID_EX_pc4   (ID_EX_pc4),
    .ID_EX_ctrl  (ID_EX_ctrl),
    .ID_EX_a     (ID_EX_a),
    .ID_EX_b     (ID_EX_b),
    .ID_EX_valid (ID_EX_valid),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, pcw, ifw, cln, fl;
    logic [31:0] npc, inst;
    logic [15:0] ctrl;
    logic [31:0] rs, rt;
    logic [31:0] e_pc, e_ifi, e_ifp;
    logic        e_ifv;
    logic [31:0] e_exi, e_exp;
    logic [15:0] e_exc;
    logic [31:0] e_exa, e_exb;
    logic        e_exv;
    logic [3:0]  e_st, e_fl;
  } vec_t;

  localparam int NV = 13;
  vec_t v [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic pw, input logic iw, input logic cl,
                       input logic f, input logic [31:0] np, input logic [31:0] im,
                       input logic [15:0] c, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    rst = r; PCWrite = pw; IF_ID_Write = iw; clean = cl; Flush = f;
    next_pc = np; imem_inst = im; id_ctrl = c; id_rs_data = a; id_rt_data = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_reset(input string tag);
    check({tag, ".pc"},          pc,          32'h0);
    check({tag, ".IF_ID_inst"},  IF_ID_inst,  32'h0);
    check({tag, ".IF_ID_pc4"},   IF_ID_pc4,   32'h0);
    check({tag, ".IF_ID_valid"}, {31'h0, IF_ID_valid}, 32'h0);
    check({tag, ".ID_EX_inst"},  ID_EX_inst,  32'h0);
    check({tag, ".ID_EX_pc4"},   ID_EX_pc4,   32'h0);
    check({tag, ".ID_EX_ctrl"},  {16'h0, ID_EX_ctrl}, 32'h0);
    check({tag, ".ID_EX_a"},     ID_EX_a,     32'h0);
    check({tag, ".ID_EX_b"},     ID_EX_b,     32'h0);
    check({tag, ".ID_EX_valid"}, {31'h0, ID_EX_valid}, 32'h0);
    check({tag, ".stall_cnt"},   {28'h0, stall_cnt}, 32'h0);
    check({tag, ".flush_cnt"},   {28'h0, flush_cnt}, 32'h0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; PCWrite = 1'b1; IF_ID_Write = 1'b1; clean = 1'b1; Flush = 1'b1;
    next_pc = 32'h0; imem_inst = 32'h0; id_ctrl = '0; id_rs_data = 32'h0; id_rt_data = 32'h0;

    //          rst pcw ifw cln fl  next_pc        imem           ctrl     rs            rt
    //          -> pc           IF inst        IF pc4         IFv EX inst      EX pc4        EX ctrl  EX a          EX b          EXv st fl
    // 0-1: reset with every control input asserted
    v[0]  = '{1,1,1,1,1, 32'h44,       32'hFFFF,     16'hAAAA, 32'h1,        32'h2,
              32'h0,       32'h0,        32'h0,        0, 32'h0,        32'h0,     16'h0,    32'h0,        32'h0,        0, 0, 0};
    v[1]  = v[0];
    // 2: first fetch A (lw) from pc=0
    v[2]  = '{0,1,1,0,0, 32'h4,        32'h8C080000, 16'h0,    32'h0,        32'h0,
              32'h4,       32'h8C080000, 32'h4,        1, 32'h0,        32'h0,     16'h0,    32'h0,        32'h0,        0, 0, 0};
    // 3: fetch B, A enters EX with its decoded operands
    v[3]  = '{0,1,1,0,0, 32'h8,        32'h01095020, 16'h1234, 32'hDEAD0001, 32'hBEEF0002,
              32'h8,       32'h01095020, 32'h8,        1, 32'h8C080000, 32'h4,     16'h1234, 32'hDEAD0001, 32'hBEEF0002, 1, 0, 0};
    // 4: fetch C (lw), B enters EX
    v[4]  = '{0,1,1,0,0, 32'hC,        32'h8D2A0004, 16'h5678, 32'h11111111, 32'h22222222,
              32'hC,       32'h8D2A0004, 32'hC,        1, 32'h01095020, 32'h8,     16'h5678, 32'h11111111, 32'h22222222, 1, 0, 0};
    // 5: load-use stall: pc and IF/ID hold, one bubble into EX
    v[5]  = '{0,0,0,1,0, 32'h10,       32'h01485820, 16'h9ABC, 32'h3,        32'h4,
              32'hC,       32'h8D2A0004, 32'hC,        1, 32'h0,        32'h0,     16'h0,    32'h0,        32'h0,        0, 1, 0};
    // 6: held instruction advances into EX
    v[6]  = '{0,1,1,0,0, 32'h10,       32'h01485820, 16'h0ABC, 32'h5,        32'h6,
              32'h10,      32'h01485820, 32'h10,       1, 32'h8D2A0004, 32'hC,     16'h0ABC, 32'h5,        32'h6,        1, 1, 0};
    // 7: flush to branch target 0x100
    v[7]  = '{0,1,1,0,1, 32'h100,      32'h12345678, 16'h1111, 32'h7,        32'h8,
              32'h100,     32'h0,        32'h0,        0, 32'h0,        32'h0,     16'h0,    32'h0,        32'h0,        0, 1, 1};
    // 8: target fetched; squashed IF/ID moves into EX as an invalid slot
    v[8]  = '{0,1,1,0,0, 32'h104,      32'h20010005, 16'h2222, 32'h9,        32'hA,
              32'h104,     32'h20010005, 32'h104,      1, 32'h0,        32'h0,     16'h2222, 32'h9,        32'hA,        0, 1, 1};
    // 9: Flush + clean with IF_ID_Write=0: flush wins, counts as flush only
    v[9]  = '{0,0,0,1,1, 32'h200,      32'hAAAA5555, 16'h7777, 32'hB,        32'hB,
              32'h104,     32'h0,        32'h0,        0, 32'h0,        32'h0,     16'h0,    32'h0,        32'h0,        0, 1, 2};
    // 10: pc to 0xFFFFFFFC, IF/ID holds its bubble
    v[10] = '{0,1,0,0,0, 32'hFFFFFFFC, 32'hAAAA5555, 16'h3333, 32'hC,        32'hD,
              32'hFFFFFFFC,32'h0,        32'h0,        0, 32'h0,        32'h0,     16'h3333, 32'hC,        32'hD,        0, 1, 2};
    // 11: capture at 0xFFFFFFFC: pc4 wraps to 0
    v[11] = '{0,1,1,0,0, 32'h0,        32'h3C01ABCD, 16'h0,    32'h0,        32'h0,
              32'h0,       32'h3C01ABCD, 32'h0,        1, 32'h0,        32'h0,     16'h0,    32'h0,        32'h0,        0, 1, 2};
    // 12: plain hold of pc and IF/ID; EX still advances
    v[12] = '{0,0,0,0,0, 32'h50,       32'h99,       16'h4444, 32'h10,       32'h11,
              32'h0,       32'h3C01ABCD, 32'h0,        1, 32'h3C01ABCD, 32'h0,     16'h4444, 32'h10,       32'h11,       1, 1, 2};

    for (int i = 0; i < NV; i++) begin
      drive(v[i].rst, v[i].pcw, v[i].ifw, v[i].cln, v[i].fl,
            v[i].npc, v[i].inst, v[i].ctrl, v[i].rs, v[i].rt);
      check($sformatf("v%0d.pc", i),          pc,                   v[i].e_pc);
      check($sformatf("v%0d.IF_ID_inst", i),  IF_ID_inst,           v[i].e_ifi);
      check($sformatf("v%0d.IF_ID_pc4", i),   IF_ID_pc4,            v[i].e_ifp);
      check($sformatf("v%0d.IF_ID_valid", i), {31'h0, IF_ID_valid}, {31'h0, v[i].e_ifv});
      check($sformatf("v%0d.ID_EX_inst", i),  ID_EX_inst,           v[i].e_exi);
      check($sformatf("v%0d.ID_EX_pc4", i),   ID_EX_pc4,            v[i].e_exp);
      check($sformatf("v%0d.ID_EX_ctrl", i),  {16'h0, ID_EX_ctrl},  {16'h0, v[i].e_exc});
      check($sformatf("v%0d.ID_EX_a", i),     ID_EX_a,              v[i].e_exa);
      check($sformatf("v%0d.ID_EX_b", i),     ID_EX_b,              v[i].e_exb);
      check($sformatf("v%0d.ID_EX_valid", i), {31'h0, ID_EX_valid}, {31'h0, v[i].e_exv});
      check($sformatf("v%0d.stall_cnt", i),   {28'h0, stall_cnt},   {28'h0, v[i].e_st});
      check($sformatf("v%0d.flush_cnt", i),   {28'h0, flush_cnt},   {28'h0, v[i].e_fl});
    end

    // Stall counter saturation: 20 clean edges from stall_cnt=1.
    for (int k = 1; k <= 20; k++) begin
      drive(0, 0, 0, 1, 0, 32'h60, 32'h0, 16'h0, 32'h0, 32'h0);
      if (k == 13) check("sat.stall_before_max", {28'h0, stall_cnt}, 32'd14);
      if (k == 14) check("sat.stall_at_max",     {28'h0, stall_cnt}, 32'd15);
    end
    check("sat.stall_final",   {28'h0, stall_cnt}, 32'd15);
    check("sat.flush_nochg",   {28'h0, flush_cnt}, 32'd2);
    check("sat.pc_held",       pc,                 32'h0);
    check("sat.IF_ID_held",    IF_ID_inst,         32'h3C01ABCD);
    check("sat.ID_EX_bubble",  {31'h0, ID_EX_valid}, 32'h0);

    // Flush counter saturation: 16 flush edges from flush_cnt=2.
    for (int k = 1; k <= 16; k++) begin
      drive(0, 1, 1, 0, 1, 32'h80, 32'h5, 16'h0, 32'h0, 32'h0);
      if (k == 12) check("sat.flush_before_max", {28'h0, flush_cnt}, 32'd14);
    end
    check("sat.flush_final",   {28'h0, flush_cnt}, 32'd15);
    check("sat.stall_kept",    {28'h0, stall_cnt}, 32'd15);

    // Build up live state, then reset during an active flush + clean.
    drive(0, 1, 1, 0, 0, 32'h90, 32'h11112222, 16'h5555, 32'h33, 32'h44);
    drive(0, 1, 1, 0, 0, 32'h94, 32'h33334444, 16'h6666, 32'h55, 32'h66);
    check("pre_rst.ID_EX_valid", {31'h0, ID_EX_valid}, 32'h1);
    check("pre_rst.ID_EX_inst",  ID_EX_inst,           32'h11112222);
    drive(1, 1, 1, 1, 1, 32'hA0, 32'h77777777, 16'h7777, 32'h77, 32'h77);
    check_all_reset("midrst");

    // No residual state: first clean edge after reset counts from zero.
    drive(0, 0, 0, 1, 0, 32'hB0, 32'h0, 16'h0, 32'h0, 32'h0);
    check("post_rst.stall_cnt", {28'h0, stall_cnt}, 32'd1);
    check("post_rst.flush_cnt", {28'h0, flush_cnt}, 32'd0);
    check("post_rst.pc",        pc,                 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
